// File: rtl/ckegen_pkg.sv
// Shared types and helpers for the multi-channel clock-enable / PWM generator.
package ckegen_pkg;

    // Output shape of a channel: single-cycle pulse per period, or PWM level.
    typedef enum logic {
        CKE_PULSE = 1'b0,
        CKE_DUTY  = 1'b1
    } cke_mode_e;

    // Width of a channel-select field; a single channel still gets one bit.
    function automatic int unsigned ckegen_sel_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/ckegen_ch.sv
// One generator channel: counter, run flag, active and shadow configuration,
// pending flag and the registered clock-enable output.
module ckegen_ch
    import ckegen_pkg::*;
#(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned DEFAULT_PERIOD = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_i,
    input  cke_mode_e        mode_i,
    output logic             pending_o,
    output logic             cke_o
);

    // The struct width follows CNT_W, so it is declared here rather than in the package.
    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        cke_mode_e        mode;
    } cke_cfg_t;

    localparam cke_cfg_t CFG_RST = '{
        period: CNT_W'(DEFAULT_PERIOD),
        high:   CNT_W'(DEFAULT_PERIOD >> 1),
        mode:   CKE_PULSE
    };

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             pending_q, pending_d;
    logic             cke_q, cke_d;
    cke_cfg_t         act_q, act_d;
    cke_cfg_t         shd_q, shd_d;
    logic             wrap;
    logic             apply;

    // Next-state: counter wrap, shadow-to-active transfer and the output level
    // computed from the next counter/run/config so cke stays aligned with cnt.
    always_comb begin
        wrap  = run_q && (cnt_q >= (act_q.period - CNT_W'(1)));
        // Running channels switch only at the wrap edge; idle ones switch at once.
        apply = pending_q && (!run_q || wrap);

        act_d = apply ? shd_q : act_q;
        shd_d = wr_i ? '{period_i, high_i, mode_i} : shd_q;

        pending_d = pending_q;
        if (wr_i) begin
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end

        run_d = run_i;
        if (!run_i || !run_q || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        cke_d = 1'b0;
        if (run_d) begin
            case (act_d.mode)
                CKE_PULSE: cke_d = (cnt_d == '0);
                CKE_DUTY:  cke_d = (cnt_d < act_d.high);
                default:   cke_d = 1'b0;
            endcase
        end
    end

    // Channel state registers; reset drops any pending configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            run_q     <= 1'b0;
            pending_q <= 1'b0;
            cke_q     <= 1'b0;
            act_q     <= CFG_RST;
            shd_q     <= CFG_RST;
        end else begin
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            pending_q <= pending_d;
            cke_q     <= cke_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
        end
    end

    assign pending_o = pending_q;
    assign cke_o     = cke_q;

endmodule

// File: rtl/cke_pwm_gen.sv
// Multi-channel clock-enable / PWM generator: configuration decode,
// ready mux and error flag around N_CH independent channels.
module cke_pwm_gen
    import ckegen_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned DEFAULT_PERIOD = 50000000,
    localparam int unsigned SEL_W         = ckegen_sel_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_mode,
    output logic             cfg_err,
    output logic [N_CH-1:0]  cke
);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr_sel;
    logic            accept;
    logic            period_zero;
    logic            cfg_err_q, cfg_err_d;

    // Ready reflects only the addressed channel's pending flag; an
    // out-of-range select is always ready and writes nowhere.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (cfg_ch == SEL_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    // Handshake decode: a zero period is flagged instead of being stored.
    always_comb begin
        accept      = cfg_valid && cfg_ready;
        period_zero = (cfg_period == '0);
        cfg_err_d   = accept && period_zero;
        wr_sel      = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            wr_sel[i] = accept && !period_zero && (cfg_ch == SEL_W'(i));
        end
    end

    // One-cycle error pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ckegen_ch #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .run_i     (ch_en[g]),
            .wr_i      (wr_sel[g]),
            .period_i  (cfg_period),
            .high_i    (cfg_high),
            .mode_i    (cke_mode_e'(cfg_mode)),
            .pending_o (pending[g]),
            .cke_o     (cke[g])
        );
    end

endmodule
